// File: rtl/shift_add_multiplier_pkg.sv
// mul_pkg: shared state encoding, default operand width and counter sizing for the shift-add multiplier.
package mul_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int DEF_WIDTH = 4;
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
    localparam int CNT_W = cnt_w(DEF_WIDTH);
endpackage

// File: rtl/mul_add_stage.sv
// mul_add_stage: combinational WIDTH-bit adder with carry-in/out; the lab 4-bit ripple adder at WIDTH=4.
module mul_add_stage
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    assign {cout, s} = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential shift-and-add multiplier, one add and one right shift per cycle.
// Define SHIFT_ADD_MULTIPLIER_SIGNED_EN for two's-complement operands and product.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = cnt_w(WIDTH);
    localparam int PW = 2 * WIDTH;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    product_q, product_d;
    logic [WIDTH-1:0] addend, sum, a_ld, b_ld;
    logic             carry;
    logic [PW-1:0]    acc_next, result;

    assign addend = acc_lo_q[0] ? mcand_q : '0;

    mul_add_stage #(.WIDTH(WIDTH)) u_add (
        .x    (acc_hi_q),
        .y    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (carry)
    );

    // The carry-out becomes the new MSB as the whole accumulator shifts right.
    assign acc_next = {carry, sum, acc_lo_q[WIDTH-1:1]};

`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
    logic sign_q, sign_d;
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction
    assign a_ld   = mag(multiplicand);
    assign b_ld   = mag(multiplier);
    assign sign_d = (state_q != CALC && start) ? multiplicand[WIDTH-1] ^ multiplier[WIDTH-1] : sign_q;
    assign result = sign_q ? -acc_next : acc_next;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sign_q <= 1'b0;
        else        sign_q <= sign_d;
`else
    assign a_ld   = multiplicand;
    assign b_ld   = multiplier;
    assign result = acc_next;
`endif

    always_comb begin
        state_d   = state_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        if (state_q == CALC) begin
            acc_hi_d = acc_next[PW-1:WIDTH];
            acc_lo_d = acc_next[WIDTH-1:0];
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                product_d = result;
                state_d   = DONE;
            end
        end else if (start) begin
            acc_hi_d = '0;
            acc_lo_d = b_ld;
            mcand_d  = a_ld;
            cnt_d    = '0;
            state_d  = CALC;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == CALC);
    assign done    = (state_q == DONE);
    assign product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed and exhaustive scoreboard bench for shift_add_multiplier.
module tb_shift_add_multiplier;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [3:0] multiplicand = '0;
    logic [3:0] multiplier = '0;
    logic       busy, done;
    logic [7:0] product;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_exp = '0;

    shift_add_multiplier #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pick(input logic [7:0] u, input logic [7:0] s);
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
        return s;
`else
        return u;
`endif
    endfunction

    function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] ax, bx;
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
        ax = {{4{a[3]}}, a};
        bx = {{4{b[3]}}, b};
`else
        ax = {4'b0, a};
        bx = {4'b0, b};
`endif
        return ax * bx;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_done: got done=1 expected no completion (product %0h)", product);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (product !== e) begin
                    n_errors++;
                    $display("FAIL product: got %0h expected %0h", product, e);
                end
            end
        end
    end

    // Issue one operation from a negedge and return at the negedge where done is seen.
    task automatic mul(input logic [3:0] a, input logic [3:0] b, input logic [7:0] e, input int inject);
        int lat, bc;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        multiplicand = ~a;
        multiplier   = ~b;
        check("product_hold", product, last_exp);
        lat = 0;
        bc  = 0;
        while (!done && lat < 20) begin
            if (busy) bc++;
            if (lat == inject) begin
                multiplicand = 4'd2;
                multiplier   = 4'd2;
                start        = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: got no done after %0d cycles expected 4", lat);
        end else begin
            check("latency", lat, 4);
            check("busy_cycles", bc, 4);
        end
        last_exp = e;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #3;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        mul(4'd13, 4'd11, pick(8'h8F, 8'h0F), -1);
        @(negedge clk);
        mul(4'd15, 4'd15, pick(8'hE1, 8'h01), -1);
        @(negedge clk);
        mul(4'd0, 4'd9, 8'h00, -1);
        @(negedge clk);
        mul(4'd1, 4'd15, pick(8'h0F, 8'hFF), -1);
        @(negedge clk);
        mul(4'd3, 4'd5, 8'h0F, -1);
        mul(4'd7, 4'd6, 8'h2A, -1);
        @(negedge clk);
        mul(4'd9, 4'd9, pick(8'h51, 8'h31), 1);
        repeat (3) @(negedge clk);
        mul(4'hD, 4'd5, pick(8'h41, 8'hF1), -1);
        mul(4'h8, 4'h8, 8'h40, -1);
        mul(4'h7, 4'hF, pick(8'h69, 8'hF9), -1);
        @(negedge clk);

        multiplicand = 4'd12;
        multiplier   = 4'd12;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_product", product, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        last_exp = '0;
        @(negedge clk);
        mul(4'd6, 4'd7, 8'h2A, -1);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                mul(4'(a), 4'(b), model(4'(a), 4'(b)), -1);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1);
    end
endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned shift-and-add multiplier; WIDTH x WIDTH operands -> 2*WIDTH product.
- One WIDTH-bit add-with-carry and one right shift per cycle.
- Sits directly downstream of the 4-bit ripple-carry adder stage and reuses it as its per-iteration datapath.
- Start/done handshake toward the lab ALU/controller.

Parameters:
- WIDTH, 4, operand width; product is 2*WIDTH bits; iteration count = WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- multiplicand  input  WIDTH  operand A; captured on accepted start
- multiplier  input  WIDTH  operand B; captured on accepted start
- busy  output  1  high while iterating
- done  output  1  one-cycle completion pulse
- product  output  2*WIDTH  registered result; held until the next completion

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low.
  - rst_n=0 forces state=IDLE, busy=0, done=0, product=0, and clears all working registers immediately, regardless of clk.
  - Reset mid-operation aborts the operation; there is no partial result.
- States:
  - IDLE: busy=0, done=0. start=1 -> load, go to CALC.
  - CALC: busy=1. Performs one iteration per edge. The WIDTH-th iteration edge goes to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. start=1 -> load, go to CALC (back-to-back). Otherwise go to IDLE.
- Load (at the accepting edge):
  - acc_hi=0, acc_lo=multiplier, mcand=multiplicand, cnt=0.
  - Operand inputs are ignored after the load edge.
- Iteration:
  - If acc_lo[0]=1, then {c, sum} = acc_hi + mcand (WIDTH-bit add with carry-out); otherwise {c, sum} = {0, acc_hi}.
  - Then {acc_hi, acc_lo} = {c, sum, acc_lo} >> 1.
  - cnt increments.
- Completion:
  - On the edge where cnt reaches WIDTH-1, {acc_hi, acc_lo} is written to product and the state moves to DONE.
- Latency: start sampled at edge T0 -> done=1 and product valid from edge T0+WIDTH through T0+WIDTH+1.
- Throughput: one multiply per WIDTH+1 cycles with back-to-back starts.
- start while busy (CALC) is ignored. It is not queued and does not alter the operands.
- product changes only at completion edges. It is stable while a new operation is running.
- Arithmetic:
  - Exact unsigned product; no overflow is possible in 2*WIDTH bits.
  - Maximum case (2^WIDTH-1)^2 must be exact.

Optional Feature:
- Macro: SHIFT_ADD_MULTIPLIER_SIGNED_EN.
- Defined: operands and product are two's complement.
  - At load, magnitudes are taken: |x| is held in WIDTH bits unsigned, so the most negative value maps to 2^(WIDTH-1).
  - The sign flag (a_msb XOR b_msb) is latched.
  - At completion, the product is negated if the flag is set.
  - Latency is unchanged; no extra cycle.
- Undefined: purely unsigned behaviour as above; no sign logic is synthesized.

Decomposition:
- Package mul_pkg holds:
  - state enum {IDLE, CALC, DONE};
  - default WIDTH constant;
  - counter width = clog2(WIDTH).
- One sub-module, mul_add_stage: combinational WIDTH-bit adder with ports x, y, cin, s, cout, instantiated with cin=0.
  - At WIDTH=4 it is the lab 4-bit adder.
  - Control FSM, shift and result registers stay in the top module.

Test Plan:
- Reset, then start with A=13, B=11 -> done pulses exactly 4 cycles after the start edge; product=143 (8'h8F); busy high for 4 cycles.
- A=15, B=15 -> product=225 (8'hE1). A=0, B=9 -> product=0. A=1, B=15 -> product=15.
- Back-to-back: 3*5 then start=1 during the done cycle with 7*6 -> products 15, then 42; no idle cycle between operations; first product holds until the second done.
- start re-asserted with A=2, B=2 during CALC of 9*9 -> ignored; product=81; only one done pulse.
- Assert rst_n=0 asynchronously at cycle 2 of 12*12 -> busy/done/product=0 immediately; after release, a new 6*7 returns 42.
- With SHIFT_ADD_MULTIPLIER_SIGNED_EN:
  - -3*5 -> 8'hF1;
  - -8*-8 -> 8'h40;
  - 7*-1 -> 8'hF9;
  - latency still 4 cycles.
- Exhaustive sweep of all 256 operand pairs against the expected product; the error count must be 0.
